mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Iterative multiply/divide unit with HI/LO registers for the multicycle MIPS datapath.
//  It consumes the A/B register outputs (operands rs/rt) alongside the Ula32 ALU.
//  It executes MULT/MULTU/DIV/DIVU over several cycles while the control unit waits.
//  HI/LO outputs feed the register-bank write-data mux for MFHI/MFLO; MTHI/MTLO load them directly.
// PARAMETERS
//  WIDTH   32   operand width; HI and LO are WIDTH bits each; iteration count = WIDTH
// PORTS
//  clk          in   1      single clock, all state updates on rising edge
//  reset        in   1      synchronous, ACTIVE-LOW reset (0 = reset, sampled on clk edge)
//  start        in   1      begin operation; sampled only in IDLE
//  op           in   2      00=MULT 01=MULTU 10=DIV 11=DIVU (latched with start)
//  a_in         in   WIDTH  operand rs (A reg output); also MTHI/MTLO data
//  b_in         in   WIDTH  operand rt (B reg output)
//  wr_hi        in   1      MTHI: HI <= a_in (IDLE only)
//  wr_lo        in   1      MTLO: LO <= a_in (IDLE only)
//  busy         out  1      1 while state != IDLE
//  done         out  1      1-cycle pulse when HI/LO hold the new result
//  div_by_zero  out  1      valid with done; 1 if DIV/DIVU had b_in==0
//  hi           out  WIDTH  HI register (MULT: upper product; DIV: remainder)
//  lo           out  WIDTH  LO register (MULT: lower product; DIV: quotient)
// BEHAVIOUR
//  - Reset (reset==0 at edge): state=IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0; aborts any op
//  - FSM IDLE -> RUN -> DONE -> IDLE. busy=1 in RUN and DONE; done=1 only in DONE
//  - IDLE: start=1 at edge E0 latches op/a_in/b_in -> RUN, count=0. start has priority over wr_hi/wr_lo
//    (same-cycle writes dropped); wr_hi and wr_lo together both load a_in
//  - Signed ops (MULT/DIV): operands converted to magnitudes at latch; result signs fixed on exit
//  - MULT/MULTU: shift-add, one bit/cycle, WIDTH RUN cycles; at edge E32: {hi,lo} <= 64-bit product, ->DONE
//  - DIV/DIVU: restoring divide, one bit/cycle, WIDTH RUN cycles; at E32: lo<=quotient, hi<=remainder
//  - Signed divide: quotient truncates toward zero; remainder takes sign of dividend
//  - 0x80000000 / 0xFFFFFFFF (DIV): lo=0x80000000, hi=0 (wraps, no trap)
//  - Divisor 0: E0 -> DONE directly (1 cycle), hi/lo unchanged, div_by_zero=1 with done
//  - DONE lasts exactly 1 cycle, then IDLE; div_by_zero clears on leaving DONE
//  - start, wr_hi, wr_lo ignored while busy (RUN or DONE); hi/lo stay stable during RUN
//  - Latency: start edge E0 -> done high in the cycle after E32 -> IDLE at E33 (div-by-zero: done after E0)
//  - No overflow flag; HI/LO are pure architectural state, no exceptions raised
// STRUCTURE
//  - Shared package (cpu_pkg): typedef enum logic[1:0] md_op_t {MD_MULT,MD_MULTU,MD_DIV,MD_DIVU};
//    typedef enum logic[1:0] md_state_t {MD_IDLE,MD_RUN,MD_DONE}
//  - Sub-module md_datapath: shift/add/subtract core (64-bit acc, count), FSM stays in the top
//  - Control unit holds its FSM in a wait state until done; mem_to_reg mux gains hi/lo inputs
// TESTING
//  - MULT 7 x 0xFFFFFFFD -> done 33 cycles after start, hi=0xFFFFFFFF lo=0xFFFFFFEB
//  - MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE lo=0x00000001
//  - DIV 0xFFFFFFF9 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU 100/7 -> lo=14 hi=2
//  - DIVU 100/0 with hi=0x11 lo=0x22 -> done+div_by_zero 1 cycle after start, hi/lo unchanged
//  - DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000 hi=0; start pulsed in RUN -> ignored, one done only
//  - reset=0 on RUN cycle 10 -> next cycle busy=0 hi=0 lo=0; wr_hi a_in=0x1234 in IDLE -> hi=0x1234

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the multicycle MIPS datapath.
// Holds the multiply/divide opcode and FSM state encodings.
package cpu_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_RUN  = 2'b01,
        MD_DONE = 2'b10
    } md_state_t;

    function automatic logic is_div(input md_op_t op);
        return op == MD_DIV || op == MD_DIVU;
    endfunction

    function automatic logic is_signed_op(input md_op_t op);
        return op == MD_MULT || op == MD_DIV;
    endfunction

endpackage

// File: rtl/md_datapath.sv
// Shift-add multiply / restoring divide core, one bit per step.
// Works on magnitudes; signs are reapplied on the final result.
module md_datapath
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  md_op_t           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc, acc_next, prod_fix;
    logic [WIDTH-1:0]   mag_b;
    logic [CW-1:0]      cnt;
    logic               div_mode, neg_q, neg_r;
    logic               sa, sb;
    logic [WIDTH:0]     mul_sum, rem_sh, diff;
    logic [WIDTH-1:0]   quo, rem;

    assign sa = is_signed_op(op) & a[WIDTH-1];
    assign sb = is_signed_op(op) & b[WIDTH-1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc      <= '0;
            mag_b    <= '0;
            cnt      <= '0;
            div_mode <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
        end else if (load) begin
            acc      <= {{WIDTH{1'b0}}, (sa ? -a : a)};
            mag_b    <= sb ? -b : b;
            cnt      <= '0;
            div_mode <= is_div(op);
            neg_q    <= sa ^ sb;
            neg_r    <= sa;
        end else if (step) begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
        end
    end

    assign last = (cnt == CW'(WIDTH - 1));

    // Multiply shifts right with the adder carry; divide shifts left
    // and keeps the trial difference only when it does not borrow.
    always_comb begin
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
                + (acc[0] ? {1'b0, mag_b} : '0);
        rem_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff    = rem_sh - {1'b0, mag_b};
        if (!div_mode)
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        else if (diff[WIDTH])
            acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        else
            acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end

    always_comb begin
        prod_fix = neg_q ? -acc_next : acc_next;
        quo      = acc_next[WIDTH-1:0];
        rem      = acc_next[2*WIDTH-1:WIDTH];
        if (div_mode) begin
            res_hi = neg_r ? -rem : rem;
            res_lo = neg_q ? -quo : quo;
        end else begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO architectural registers.
// Control FSM here; arithmetic lives in md_datapath.
module mult_div_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             wr_hi,
    input  logic             wr_lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_t        state, state_next;
    md_op_t           op_sel;
    logic             load, step, last, zero_div;
    logic [WIDTH-1:0] res_hi, res_lo;

    assign op_sel   = md_op_t'(op);
    assign zero_div = is_div(op_sel) && (b_in == '0);

    md_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .step   (step),
        .op     (op_sel),
        .a      (a_in),
        .b      (b_in),
        .last   (last),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= MD_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            MD_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    load       = 1'b1;
                    state_next = zero_div ? MD_DONE : MD_RUN;
                end
            end
            MD_RUN: begin
                step = 1'b1;
                if (last) state_next = MD_DONE;
            end
            MD_DONE: begin
                done       = 1'b1;
                state_next = MD_IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = MD_IDLE;
            end
        endcase
    end

    // start wins over same-cycle MTHI/MTLO; writes are ignored while busy
    always_ff @(posedge clk) begin
        if (!reset) begin
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        div_by_zero <= zero_div;
                    end else begin
                        if (wr_hi) hi <= a_in;
                        if (wr_lo) lo <= a_in;
                    end
                end
                MD_RUN: begin
                    if (last) begin
                        hi <= res_hi;
                        lo <= res_lo;
                    end
                end
                MD_DONE: div_by_zero <= 1'b0;
                default: div_by_zero <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed checks for mult_div_unit: products, quotients, div-by-zero,
// latency, busy-time write/start rejection, reset abort and MTHI/MTLO.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic        wr_hi = 1'b0;
    logic        wr_lo = 1'b0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    int lat;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a_in        (a_in),
        .b_in        (b_in),
        .wr_hi       (wr_hi),
        .wr_lo       (wr_lo),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge; returns with lat = edges from start edge to done.
    // At run cycle pulse_cyc a start and an MTHI are attempted; HI must hold.
    task automatic run(input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input int pulse_cyc,
                       input logic [31:0] hold, output int n);
        op    = o;
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        while (!done && n < 100) begin
            if (n == pulse_cyc) begin
                start = 1'b1;
                wr_hi = 1'b1;
                op    = 2'b01;
                a_in  = 32'h0000_DEAD;
                b_in  = 32'h0000_0003;
            end
            tick();
            if (n == pulse_cyc) begin
                start = 1'b0;
                wr_hi = 1'b0;
                chk("hold_hi_in_run", hi, hold);
                chk("busy_in_run", 32'(busy), 32'd1);
            end
            n++;
        end
    endtask

    task automatic after_done(input string tag);
        tick();
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
        chk({tag, "_done_after"}, 32'(done), 32'd0);
        chk({tag, "_dbz_after"}, 32'(div_by_zero), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        reset = 1'b1;
        tick();

        // MULT 7 x -3 = -21
        run(2'b00, 32'd7, 32'hFFFF_FFFD, 0, 32'd0, lat);
        chk("mult_lat", 32'(lat), 32'd33);
        chk("mult_done", 32'(done), 32'd1);
        chk("mult_busy", 32'(busy), 32'd1);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFEB);
        chk("mult_dbz", 32'(div_by_zero), 32'd0);
        after_done("mult");

        run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'd0, lat);
        chk("multu_lat", 32'(lat), 32'd33);
        chk("multu_hi", hi, 32'hFFFF_FFFE);
        chk("multu_lo", lo, 32'h0000_0001);
        after_done("multu");

        run(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 32'd0, lat);
        chk("div_lat", 32'(lat), 32'd33);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        after_done("div");

        run(2'b11, 32'd100, 32'd7, 0, 32'd0, lat);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);
        after_done("divu");

        // MTHI then MTLO
        a_in  = 32'h11;
        wr_hi = 1'b1;
        tick();
        wr_hi = 1'b0;
        a_in  = 32'h22;
        wr_lo = 1'b1;
        tick();
        wr_lo = 1'b0;
        chk("mthi", hi, 32'h11);
        chk("mtlo", lo, 32'h22);

        run(2'b11, 32'd100, 32'd0, 0, 32'd0, lat);
        chk("dbz_lat", 32'(lat), 32'd1);
        chk("dbz_done", 32'(done), 32'd1);
        chk("dbz_flag", 32'(div_by_zero), 32'd1);
        chk("dbz_hi", hi, 32'h11);
        chk("dbz_lo", lo, 32'h22);
        after_done("dbz");

        // Overflow-ish signed divide with a start pulsed mid-run
        run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5, 32'h11, lat);
        chk("divmin_lat", 32'(lat), 32'd33);
        chk("divmin_lo", lo, 32'h8000_0000);
        chk("divmin_hi", hi, 32'h0);
        after_done("divmin");
        tick();
        chk("divmin_no_second_done", 32'(done), 32'd0);
        chk("divmin_idle", 32'(busy), 32'd0);

        // MTHI and MTLO together
        a_in  = 32'hABCD;
        wr_hi = 1'b1;
        wr_lo = 1'b1;
        tick();
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        chk("mtboth_hi", hi, 32'hABCD);
        chk("mtboth_lo", lo, 32'hABCD);

        // start wins over a same-cycle MTHI; HI holds through RUN
        wr_hi = 1'b1;
        run(2'b11, 32'd100, 32'd7, 10, 32'hABCD, lat);
        chk("divu2_lo", lo, 32'd14);
        chk("divu2_hi", hi, 32'd2);
        after_done("divu2");

        // Reset aborts an op in flight
        op    = 2'b01;
        a_in  = 32'd5;
        b_in  = 32'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        chk("pre_abort_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        tick();
        chk("abort_stays_idle", 32'(busy), 32'd0);

        a_in  = 32'h1234;
        wr_hi = 1'b1;
        tick();
        wr_hi = 1'b0;
        chk("mthi_1234", hi, 32'h1234);
        chk("mthi_lo_kept", lo, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
